cordic_vertex_rotator: RTL and testbench
========================================

Name: cordic_vertex_rotator

Overview:
Parametrised, iterative CORDIC rotation engine. It rotates NV polygon vertices in parallel by one signed angle and processes one micro-rotation per clock. It is the multi-iteration successor to the single-step CORDIC stage in the rasteriser geometry pipeline. Pixel/colour/form sideband passes through untouched, and a bypass (bubble) mode forwards vertices without rotation.

Parameters:
W, 19, signed vertex coordinate width
ZW, 9, signed angle width; z unit = 1 degree
NV, 4, number of vertices rotated in parallel (1..8)
ITER, 8, micro-rotations per transaction (1..15)
SBW, 39, sideband width (bubble, colour, pixel x/y, ref point, form)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  engine can accept a transaction
in_bypass  in  1  forward vertices unrotated
in_vx  in  NV*W  vertex x, vertex k at bits [k*W +: W]
in_vy  in  NV*W  vertex y, same packing
in_z  in  ZW  signed rotation angle, degrees
in_sb  in  SBW  sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vx  out  NV*W  rotated x
out_vy  out  NV*W  rotated y
out_z  out  ZW  residual angle
out_sb  out  SBW  sideband captured with the transaction
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous, active-low. When reset=0 at an edge: state=IDLE, iteration counter=0, out_valid=0, and out_vx/out_vy/out_z/out_sb=0. The reset is honoured mid-transaction; the in-flight transaction is discarded and not emitted.
- FSM has three states: IDLE, ROTATE, DONE.
- in_ready = (state==IDLE), combinational. out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, capture vx, vy, z, sb into working registers and set the counter i=0.
  - in_bypass=1: next state DONE.
  - otherwise: next state ROTATE.
- ROTATE: one micro-rotation per edge on all NV vertices simultaneously.
  - d=+1 if z>=0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - Shifts are arithmetic. Results are truncated to W/ZW bits, two's-complement wrap, no saturation.
  - ATAN ROM, indexed by i: 45, 27, 14, 7, 4, 2, 1, 0. Entries at i>=8 are 0.
  - When i==ITER-1, next state DONE; otherwise i<=i+1.
- DONE: outputs hold stable while out_ready=0. On out_ready=1, next state IDLE. in_ready rises on the following cycle; there is no same-cycle turnaround.
- Latency:
  - Rotation: out_valid is high ITER+1 edges after the accepting edge.
  - Bypass: out_valid is high 1 edge after the accepting edge.
  - Throughput: at most one transaction per ITER+2 cycles.
- No gain compensation: rotated outputs are scaled by K≈1.647 (ITER=8). Callers keep |x|,|y| < 2^(W-1)/1.65 to avoid wrap.
- Bypass: out_vx/out_vy/out_z are equal to the captured inputs, bit-exact.
- out_sb is always the sb captured at acceptance, in both modes.
- in_* are ignored when in_ready=0. Transactions are never dropped or duplicated.
- Output registers are updated only on state transitions into DONE and hold their last value in IDLE. Only out_valid qualifies them.
- Exact angle coverage: |in_z| <= 100 degrees. Beyond that, out_z carries the unresolved remainder.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1 after release.
- +90 degree rotation: NV=4, ITER=8, every vertex (100,0), z=90 -> after 9 edges each out_vx in [-4,4], out_vy in [160,168], out_z=0.
- -90 degree rotation: every vertex (0,100), z=-90 -> each out_vx in [160,168], out_vy in [-4,4], out_z=0.
- Bypass: in_bypass=1, vertices (7,-3), z=33, sb=0x5A5A5A5A5 -> out_valid 1 edge later; outputs identical to inputs.
- Backpressure and busy: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. A second in_valid pulse during ROTATE is not accepted. Raising out_ready -> IDLE next edge, then the next transaction is accepted.
- Reset mid-op: assert reset=0 at iteration 3 -> no out_valid ever appears for that transaction. A subsequent bypass transaction completes normally.

Source files
------------

// File: rtl/cordic_vertex_rotator_if.sv
// Transaction bundle for the vertex rotator: input handshake, vertices, angle and sideband in;
// rotated result and handshake out.
interface cordic_vertex_rotator_if #(
  parameter int W   = 19,
  parameter int ZW  = 9,
  parameter int NV  = 4,
  parameter int SBW = 39
);
  logic            in_valid;
  logic            in_ready;
  logic            in_bypass;
  logic [NV*W-1:0] in_vx;
  logic [NV*W-1:0] in_vy;
  logic [ZW-1:0]   in_z;
  logic [SBW-1:0]  in_sb;
  logic            out_valid;
  logic            out_ready;
  logic [NV*W-1:0] out_vx;
  logic [NV*W-1:0] out_vy;
  logic [ZW-1:0]   out_z;
  logic [SBW-1:0]  out_sb;

  modport master (
    output in_valid, in_bypass, in_vx, in_vy, in_z, in_sb, out_ready,
    input  in_ready, out_valid, out_vx, out_vy, out_z, out_sb
  );

  modport slave (
    input  in_valid, in_bypass, in_vx, in_vy, in_z, in_sb, out_ready,
    output in_ready, out_valid, out_vx, out_vy, out_z, out_sb
  );
endinterface

// File: rtl/cordic_vertex_rotator.sv
// Iterative CORDIC rotator: NV vertices turned by one signed angle (degrees), one micro-rotation per clock.
//   state  | meaning
//   IDLE   | ready for a transaction; outputs hold the last result
//   ROTATE | one micro-rotation per edge on all vertices
//   DONE   | result valid, held until out_ready
module cordic_vertex_rotator #(
  parameter int W    = 19,
  parameter int ZW   = 9,
  parameter int NV   = 4,
  parameter int ITER = 8,
  parameter int SBW  = 39
) (
  input  logic                   clk,
  input  logic                   reset,
  cordic_vertex_rotator_if.slave bus,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t                state_q;
  logic [3:0]            iter_q;
  logic signed [W-1:0]   x_q [NV];
  logic signed [W-1:0]   y_q [NV];
  logic signed [W-1:0]   x_d [NV];
  logic signed [W-1:0]   y_d [NV];
  logic signed [ZW-1:0]  z_q, z_d;
  logic [SBW-1:0]        sb_q;
  logic [NV*W-1:0]       rot_vx_d, rot_vy_d;
  logic [NV*W-1:0]       out_vx_q, out_vy_q;
  logic [ZW-1:0]         out_z_q;
  logic [SBW-1:0]        out_sb_q;

  function automatic logic signed [ZW-1:0] atan_deg(input logic [3:0] i);
    case (i)
      4'd0:    atan_deg = ZW'(45);
      4'd1:    atan_deg = ZW'(27);
      4'd2:    atan_deg = ZW'(14);
      4'd3:    atan_deg = ZW'(7);
      4'd4:    atan_deg = ZW'(4);
      4'd5:    atan_deg = ZW'(2);
      4'd6:    atan_deg = ZW'(1);
      default: atan_deg = '0;
    endcase
  endfunction

  // A negative residual angle rotates clockwise (d = -1).
  always_comb begin
    rot_vx_d = '0;
    rot_vy_d = '0;
    for (int k = 0; k < NV; k++) begin
      x_d[k] = z_q[ZW-1] ? x_q[k] + (y_q[k] >>> iter_q) : x_q[k] - (y_q[k] >>> iter_q);
      y_d[k] = z_q[ZW-1] ? y_q[k] - (x_q[k] >>> iter_q) : y_q[k] + (x_q[k] >>> iter_q);
      rot_vx_d[k*W +: W] = x_d[k];
      rot_vy_d[k*W +: W] = y_d[k];
    end
    z_d = z_q[ZW-1] ? z_q + atan_deg(iter_q) : z_q - atan_deg(iter_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      z_q      <= '0;
      sb_q     <= '0;
      out_vx_q <= '0;
      out_vy_q <= '0;
      out_z_q  <= '0;
      out_sb_q <= '0;
      for (int k = 0; k < NV; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NV; k++) begin
              x_q[k] <= bus.in_vx[k*W +: W];
              y_q[k] <= bus.in_vy[k*W +: W];
            end
            z_q    <= bus.in_z;
            sb_q   <= bus.in_sb;
            iter_q <= '0;
            if (bus.in_bypass) begin
              state_q  <= DONE;
              out_vx_q <= bus.in_vx;
              out_vy_q <= bus.in_vy;
              out_z_q  <= bus.in_z;
              out_sb_q <= bus.in_sb;
            end else begin
              state_q <= ROTATE;
            end
          end
        end
        ROTATE: begin
          for (int k = 0; k < NV; k++) begin
            x_q[k] <= x_d[k];
            y_q[k] <= y_d[k];
          end
          z_q <= z_d;
          if (iter_q == 4'(ITER-1)) begin
            state_q  <= DONE;
            out_vx_q <= rot_vx_d;
            out_vy_q <= rot_vy_d;
            out_z_q  <= z_d;
            out_sb_q <= sb_q;
          end else begin
            iter_q <= iter_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_vx    = out_vx_q;
  assign bus.out_vy    = out_vy_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_sb    = out_sb_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_cordic_vertex_rotator.sv
// Randomised and directed bench for cordic_vertex_rotator against a plain-integer CORDIC model.
module tb_cordic_vertex_rotator;
  localparam int W = 19, ZW = 9, NV = 4, ITER = 8, SBW = 39;
  localparam int NVW = NV * W;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  cordic_vertex_rotator_if #(.W(W), .ZW(ZW), .NV(NV), .SBW(SBW)) bus ();

  cordic_vertex_rotator #(.W(W), .ZW(ZW), .NV(NV), .ITER(ITER), .SBW(SBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v, input int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits - 1))) m -= (1 << bits);
    return m;
  endfunction

  // floor(v / 2^i), the arithmetic meaning of an arithmetic right shift
  function automatic int floor_div(input int v, input int i);
    int p;
    p = 1 << i;
    return (v >= 0) ? v / p : -((-v + p - 1) / p);
  endfunction

  function automatic int atan_tab(input int i);
    int t[8] = '{45, 27, 14, 7, 4, 2, 1, 0};
    return (i < 8) ? t[i] : 0;
  endfunction

  function automatic void model(input logic [NVW-1:0] vx, input logic [NVW-1:0] vy,
                                input logic [ZW-1:0] z, input bit byp,
                                output logic [NVW-1:0] ox, output logic [NVW-1:0] oy,
                                output logic [ZW-1:0] oz);
    int x, y, xn, zz, zn, d;
    ox = vx; oy = vy; oz = z;
    if (byp) return;
    for (int k = 0; k < NV; k++) begin
      x  = $signed(vx[k*W +: W]);
      y  = $signed(vy[k*W +: W]);
      zz = $signed(z);
      for (int i = 0; i < ITER; i++) begin
        d  = (zz >= 0) ? 1 : -1;
        xn = wrap(x - d * floor_div(y, i), W);
        y  = wrap(y + d * floor_div(x, i), W);
        x  = xn;
        zn = wrap(zz - d * atan_tab(i), ZW);
        zz = zn;
      end
      ox[k*W +: W] = W'(x);
      oy[k*W +: W] = W'(y);
      oz = ZW'(zz);
    end
  endfunction

  task automatic run_txn(input bit byp, input logic [NVW-1:0] vx, input logic [NVW-1:0] vy,
                         input logic [ZW-1:0] z, input logic [SBW-1:0] sb,
                         input int hold, input bit poke);
    logic [NVW-1:0] ex, ey;
    logic [ZW-1:0]  ez;
    int edges, guard;
    model(vx, vy, z, byp, ex, ey, ez);
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_bypass = byp;
    bus.in_vx = vx; bus.in_vy = vy; bus.in_z = z; bus.in_sb = sb;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_bypass = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < ITER + 4) begin
      if (poke && edges == 2) begin
        check("busy_rotate", busy, 1);
        check("ready_rotate", bus.in_ready, 0);
        bus.in_valid = 1'b1; bus.in_bypass = 1'b1;
        bus.in_vx = ~vx; bus.in_z = ~z; bus.in_sb = ~sb;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_bypass = 1'b0;
      edges++;
    end
    check("latency", edges, byp ? 1 : ITER + 1);
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", bus.out_valid, 1);
      check("ready_done", bus.in_ready, 0);
      check("out_vx", bus.out_vx, ex);
      check("out_vy", bus.out_vy, ey);
      check("out_z", bus.out_z, ez);
      check("out_sb", bus.out_sb, sb);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  function automatic logic [NVW-1:0] rep(input int v);
    logic [NVW-1:0] r;
    for (int k = 0; k < NV; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NVW-1:0] vx, vy;
    logic [ZW-1:0]  z;
    logic [SBW-1:0] sb;
    int xv, yv, seen;

    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_bypass = 1'b0;
    bus.in_vx = rep(11); bus.in_vy = rep(22); bus.in_z = ZW'(5); bus.in_sb = '1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_vx", bus.out_vx, 0);
    check("rst_vy", bus.out_vy, 0);
    check("rst_z", bus.out_z, 0);
    check("rst_sb", bus.out_sb, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", bus.in_ready, 1);

    // +90 and -90 degree rotations with bounds on the gain-scaled result
    run_txn(1'b0, rep(100), rep(0), ZW'(90), SBW'(39'h1234567), 0, 1'b0);
    for (int k = 0; k < NV; k++) begin
      xv = $signed(bus.out_vx[k*W +: W]);
      yv = $signed(bus.out_vy[k*W +: W]);
      check("p90_x_rng", (xv >= -4 && xv <= 4), 1);
      check("p90_y_rng", (yv >= 160 && yv <= 168), 1);
    end
    check("p90_z", bus.out_z, 0);

    run_txn(1'b0, rep(0), rep(100), ZW'(-90), SBW'(39'h7654321), 0, 1'b0);
    for (int k = 0; k < NV; k++) begin
      xv = $signed(bus.out_vx[k*W +: W]);
      yv = $signed(bus.out_vy[k*W +: W]);
      check("m90_x_rng", (xv >= 160 && xv <= 168), 1);
      check("m90_y_rng", (yv >= -4 && yv <= 4), 1);
    end
    check("m90_z", bus.out_z, 0);

    run_txn(1'b1, rep(7), rep(-3), ZW'(33), SBW'(39'h5A5A5A5A5), 0, 1'b0);

    // backpressure plus a rejected second request during ROTATE
    run_txn(1'b0, rep(1234), rep(-567), ZW'(-45), SBW'(39'h0F0F0F0F0), 10, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_dup", bus.out_valid, 0);
    end

    // reset during iteration 3 discards the transaction
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_bypass = 1'b0;
    bus.in_vx = rep(500); bus.in_vy = rep(200); bus.in_z = ZW'(60); bus.in_sb = SBW'(39'h3C3C);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vx", bus.out_vx, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (ITER + 4) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("mid_rst_ghost", seen, 0);
    run_txn(1'b1, rep(-42), rep(77), ZW'(-12), SBW'(39'h1ABCDEF01), 1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < NV; k++) begin
        vx[k*W +: W] = W'(int'($urandom_range(120000)) - 60000);
        vy[k*W +: W] = W'(int'($urandom_range(120000)) - 60000);
      end
      z  = ZW'(int'($urandom_range(200)) - 100);
      sb = SBW'({$urandom(), $urandom()});
      run_txn($urandom_range(3) == 0, vx, vy, z, sb, int'($urandom_range(3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
